burst_line_adaptor: RTL and testbench

Sits directly downstream of `eviction_write_buffer`, on its `pmem_*` port. It converts each 256-bit line transaction into a 4-beat, 64-bit burst on the DRAM-side bus. Read bursts are assembled into a full line, and write lines are serialised into beats. `line_resp` is returned once per completed line, so the write buffer sees ordinary single-response physical memory.

---
 rtl/burst_pkg.sv | 15 +
 rtl/burst_line_shifter.sv | 41 ++++
 rtl/burst_line_adaptor.sv | 155 +++++++++++++++
 tb/tb_burst_line_adaptor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared types and constants for the line-to-burst adaptor.
// Burst FSM states, line offset width and beats per line.
package burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } burst_state_t;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEATS            = 4;

endpackage

// File: rtl/burst_line_shifter.sv
// Beat register holding one line as BEATS slots of BEAT_WIDTH bits.
// Read bursts write one slot per beat; write bursts select one slot per beat.
import burst_pkg::*;

module burst_line_shifter #(
    parameter int BEAT_WIDTH = 64,
    parameter int NBEATS     = BEATS,
    parameter int CNT_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NBEATS*BEAT_WIDTH-1:0] load_line,
    input  logic                         wr_en,
    input  logic [CNT_W-1:0]             wr_idx,
    input  logic [BEAT_WIDTH-1:0]        wr_beat,
    input  logic [CNT_W-1:0]             sel_idx,
    output logic [BEAT_WIDTH-1:0]        sel_beat,
    output logic [NBEATS*BEAT_WIDTH-1:0] line_q
);

    logic [BEAT_WIDTH-1:0] slot [NBEATS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBEATS; i++) slot[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < NBEATS; i++) slot[i] <= load_line[i*BEAT_WIDTH +: BEAT_WIDTH];
        end else if (wr_en) begin
            slot[wr_idx] <= wr_beat;
        end
    end

    assign sel_beat = slot[sel_idx];

    always_comb begin
        line_q = '0;
        for (int i = 0; i < NBEATS; i++) line_q[i*BEAT_WIDTH +: BEAT_WIDTH] = slot[i];
    end

endmodule

// File: rtl/burst_line_adaptor.sv
// Converts single line read/write transactions into ascending-order beat bursts.
// Optional watchdog abort is built when BURST_TIMEOUT_EN is defined.
import burst_pkg::*;

module burst_line_adaptor #(
    parameter int LINE_WIDTH     = 256,
    parameter int BEAT_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    input  logic                  line_read,
    input  logic                  line_write,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [31:0]           burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp,
    output logic                  burst_err
);

    localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    burst_state_t           state, next_state;
    logic [CNT_W-1:0]       cnt;
    logic                   start_rd, start_wr, beat, last_beat, timeout_hit, timeout;
    logic [BEAT_WIDTH-1:0]  sel_beat;
    logic [LINE_WIDTH-1:0]  line_q, rd_merged;
    logic                   unused_offset;

    assign unused_offset = ^line_address[LINE_OFFSET_BITS-1:0];

`ifdef BURST_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (start_rd || start_wr || beat) begin
            idle_cnt <= '0;
        end else if (state == RD || state == WR) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign timeout_hit = (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Write wins when both requests are seen together.
    always_comb begin
        next_state = state;
        start_rd   = 1'b0;
        start_wr   = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (line_write) begin
                    start_wr   = 1'b1;
                    next_state = WR;
                end else if (line_read) begin
                    start_rd   = 1'b1;
                    next_state = RD;
                end
            end
            RD, WR: begin
                if (burst_resp) begin
                    beat = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        last_beat  = 1'b1;
                        next_state = DONE;
                    end
                end else if (timeout_hit) begin
                    timeout    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    burst_line_shifter #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .NBEATS     (NBEATS),
        .CNT_W      (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_rd || start_wr),
        .load_line (start_wr ? line_wdata : '0),
        .wr_en     (beat && state == RD),
        .wr_idx    (cnt),
        .wr_beat   (burst_rdata),
        .sel_idx   (CNT_W'(cnt + 1'b1)),
        .sel_beat  (sel_beat),
        .line_q    (line_q)
    );

    // Completed line including the beat arriving this cycle.
    always_comb begin
        rd_merged = line_q;
        if (beat) rd_merged[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_rdata    <= '0;
            line_resp     <= 1'b0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_wdata   <= '0;
            burst_err     <= 1'b0;
            cnt           <= '0;
        end else begin
            line_resp <= last_beat || timeout;
            burst_err <= timeout;
            if (start_rd || start_wr) begin
                burst_address <= {line_address[31:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
                cnt           <= '0;
                burst_read    <= start_rd;
                burst_write   <= start_wr;
                if (start_wr) burst_wdata <= line_wdata[BEAT_WIDTH-1:0];
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
                if (state == WR && !last_beat) burst_wdata <= sel_beat;
            end
            if (last_beat || timeout) begin
                burst_read  <= 1'b0;
                burst_write <= 1'b0;
                if (state == RD) line_rdata <= rd_merged;
            end
        end
    end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor; the timeout case runs when BURST_TIMEOUT_EN is defined.
module tb_burst_line_adaptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic         line_read, line_write;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic         burst_read, burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;
    logic         burst_err;

    int tests    = 0;
    int failures = 0;
    int resp_seen = 0;

    burst_line_adaptor #(
        .LINE_WIDTH     (256),
        .BEAT_WIDTH     (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp),
        .burst_err     (burst_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (line_resp) resp_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [255:0] exp_rdata);
        check({tag, "_rdata"}, line_rdata, exp_rdata);
        check({tag, "_resp"},  line_resp, 0);
        check({tag, "_addr"},  burst_address, 0);
        check({tag, "_rd"},    burst_read, 0);
        check({tag, "_wr"},    burst_write, 0);
        check({tag, "_wdata"}, burst_wdata, 0);
        check({tag, "_err"},   burst_err, 0);
    endtask

    // Read with back-to-back beats; line_resp expected in cycle 5.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [255:0] line);
        line_read = 1'b1;
        line_address = addr;
        tick();
        check("rd_req", burst_read, 1);
        check("rd_addr", burst_address, exp_addr);
        for (int b = 0; b < 4; b++) begin
            burst_resp = 1'b1;
            burst_rdata = line[b*64 +: 64];
            tick();
            if (b < 3) check("rd_busy", {line_resp, burst_read}, 2'b01);
        end
        burst_resp = 1'b0;
        check("rd_resp", line_resp, 1);
        check("rd_drop", burst_read, 0);
        check("rd_data", line_rdata, line);
        line_read = 1'b0;
        tick();
        check("rd_resp_off", line_resp, 0);
    endtask

    logic [255:0] wline;
    logic [255:0] rline;
    int           resp_base;

    initial begin
        rst_n = 1'b0;
        line_address = '0;
        line_wdata = '0;
        line_read = 1'b0;
        line_write = 1'b0;
        burst_rdata = '0;
        burst_resp = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset", 256'd0);
        rst_n = 1'b1;
        tick();

        // Read, no wait states
        rline = {64'd3, 64'd2, 64'd1, 64'd0};
        do_read(32'h0000_1234, 32'h0000_1220, rline);

        // Write, one wait state between beats; inputs change mid-burst
        wline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_write = 1'b1;
        line_address = 32'hABCD_EF7F;
        line_wdata = wline;
        tick();
        check("wr_req", burst_write, 1);
        check("wr_noread", burst_read, 0);
        check("wr_addr", burst_address, 32'hABCD_EF60);
        check("wr_beat0", burst_wdata, 64'h1111_1111_1111_1111);
        line_wdata = ~wline;
        line_address = 32'h0000_0040;
        for (int k = 0; k < 4; k++) begin
            burst_resp = 1'b1;
            tick();
            burst_resp = 1'b0;
            if (k < 3) begin
                check("wr_beat", burst_wdata, wline[(k+1)*64 +: 64]);
                check("wr_busy", {line_resp, burst_write}, 2'b01);
                tick();
                check("wr_hold", burst_wdata, wline[(k+1)*64 +: 64]);
                check("wr_addr_hold", burst_address, 32'hABCD_EF60);
            end
        end
        check("wr_resp", line_resp, 1);
        check("wr_drop", burst_write, 0);
        check("wr_keep_rdata", line_rdata, rline);
        line_write = 1'b0;
        tick();
        check("wr_resp_off", line_resp, 0);

        // Read and write together: write wins
        line_read = 1'b1;
        line_write = 1'b1;
        line_address = 32'h0000_0080;
        line_wdata = {64'hDD, 64'hCC, 64'hBB, 64'hAA};
        tick();
        check("both_wr", burst_write, 1);
        check("both_rd", burst_read, 0);
        check("both_beat0", burst_wdata, 64'hAA);
        for (int b = 0; b < 4; b++) begin
            burst_resp = 1'b1;
            tick();
            if (b < 3) check("both_noread", burst_read, 0);
        end
        burst_resp = 1'b0;
        check("both_resp", line_resp, 1);
        check("both_rdata", line_rdata, rline);
        line_read = 1'b0;
        line_write = 1'b0;
        tick();

        // Reset mid-read after two beats
        line_read = 1'b1;
        line_address = 32'h0000_0040;
        tick();
        burst_resp = 1'b1;
        burst_rdata = 64'hAA;
        tick();
        burst_rdata = 64'hBB;
        tick();
        burst_resp = 1'b0;
        check("mid_busy", burst_read, 1);
        #2;
        rst_n = 1'b0;
        line_read = 1'b0;
        #1;
        check_idle_outputs("midrst", 256'd0);
        resp_base = resp_seen;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_noresp", resp_seen - resp_base, 0);
        rline = {64'd8, 64'd7, 64'd6, 64'd5};
        do_read(32'h2000_0008, 32'h2000_0000, rline);

        // Spurious response in IDLE, then back-to-back read and write
        burst_resp = 1'b1;
        tick();
        tick();
        burst_resp = 1'b0;
        check("spur_resp", line_resp, 0);
        check("spur_busy", {burst_read, burst_write}, 2'b00);
        resp_base = resp_seen;
        line_read = 1'b1;
        line_address = 32'h0000_0100;
        tick();
        for (int b = 0; b < 4; b++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'h9 + 64'(b);
            tick();
        end
        burst_resp = 1'b0;
        check("b2b_rd_resp", line_resp, 1);
        check("b2b_rd_data", line_rdata, {64'hC, 64'hB, 64'hA, 64'h9});
        line_read = 1'b0;
        line_write = 1'b1;
        line_address = 32'h0000_0200;
        wline = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        line_wdata = wline;
        tick();
        check("b2b_gap", {line_resp, burst_read, burst_write}, 3'b000);
        tick();
        check("b2b_wr_req", burst_write, 1);
        check("b2b_wr_addr", burst_address, 32'h0000_0200);
        for (int b = 0; b < 4; b++) begin
            check("b2b_wr_beat", burst_wdata, wline[b*64 +: 64]);
            burst_resp = 1'b1;
            tick();
        end
        burst_resp = 1'b0;
        check("b2b_wr_resp", line_resp, 1);
        line_write = 1'b0;
        tick();
        tick();
        check("b2b_resp_count", resp_seen - resp_base, 2);

`ifdef BURST_TIMEOUT_EN
        // Read with no responses aborts after 8 idle cycles
        line_read = 1'b1;
        line_address = 32'h0000_0300;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check("to_wait", {burst_err, line_resp, burst_read}, 3'b001);
            if (c < 8) tick();
        end
        tick();
        check("to_err", burst_err, 1);
        check("to_resp", line_resp, 1);
        check("to_rdata", line_rdata, 256'd0);
        line_read = 1'b0;
        tick();
        check("to_idle", {burst_err, line_resp, burst_read}, 3'b000);
`else
        // Long stall: burst waits and never flags an error
        line_read = 1'b1;
        line_address = 32'h0000_0300;
        tick();
        for (int c = 0; c < 20; c++) tick();
        check("stall_busy", {burst_err, line_resp, burst_read}, 3'b001);
        for (int b = 0; b < 4; b++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'h50 + 64'(b);
            tick();
        end
        burst_resp = 1'b0;
        check("stall_resp", {burst_err, line_resp}, 2'b01);
        check("stall_data", line_rdata, {64'h53, 64'h52, 64'h51, 64'h50});
        line_read = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
